mem_wb_pipe: RTL and testbench

- Parametrised successor to the single-stage memory-to-writeback pipeline register.
- Carries the write-enable, result and destination-register fields through DEPTH stages, each with its own valid bit.
- Adds synchronous reset, pipeline flush, and two in-flight forwarding lookup ports that the decode/execute hazard logic uses to bypass results not yet written back.
- Adds a retired-write counter for the core's performance registers.

---
 rtl/mem_wb_if.sv | 29 ++
 rtl/mem_wb_pipe.sv | 124 ++++++++++++
 tb/tb_mem_wb_pipe.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_if.sv
// mem_wb_if: memory-to-writeback pipeline bus.
//   Entry side (driven by the producer): vld_i, rwe_i, res_i, c_reg_i.
//   Writeback side (driven by the pipe): vld_o, rwe_o, res_o, c_reg_o.
//   master: the producer / register-file side.
//   slave:  the pipeline register itself.
interface mem_wb_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 8
);
  logic              vld_i;
  logic              rwe_i;
  logic [DATA_W-1:0] res_i;
  logic [REG_W-1:0]  c_reg_i;

  logic              vld_o;
  logic              rwe_o;
  logic [DATA_W-1:0] res_o;
  logic [REG_W-1:0]  c_reg_o;

  modport master (
    output vld_i, rwe_i, res_i, c_reg_i,
    input  vld_o, rwe_o, res_o, c_reg_o
  );

  modport slave (
    input  vld_i, rwe_i, res_i, c_reg_i,
    output vld_o, rwe_o, res_o, c_reg_o
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: DEPTH-stage memory-to-writeback pipeline register with
// per-stage valid bits, flush, stall, two in-flight forwarding lookup ports
// and a retired-write counter.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   stall             hold every stage, drop the input
//   flush             clear every valid bit (wins over stall)
//   bus               entry in (vld_i/rwe_i/res_i/c_reg_i), writeback out
//                     (vld_o/rwe_o/res_o/c_reg_o)
//   fwd_reg_a/b       source register queried by lookup port A/B
//   fwd_hit_a/b       a valid in-flight write targets that register
//   fwd_data_a/b      result of the youngest matching write, else 0
//   wb_cnt            number of cycles on which rwe_o was 1 (wraps)
module mem_wb_pipe #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 8,
  parameter int DEPTH   = 1,
  parameter int R0_ZERO = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  mem_wb_if.slave           bus,
  input  logic [REG_W-1:0]  fwd_reg_a,
  output logic              fwd_hit_a,
  output logic [DATA_W-1:0] fwd_data_a,
  input  logic [REG_W-1:0]  fwd_reg_b,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic [CNT_W-1:0]  wb_cnt
);

  typedef struct packed {
    logic              vld;
    logic              rwe;
    logic [DATA_W-1:0] res;
    logic [REG_W-1:0]  c_reg;
  } stage_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } fwd_t;

  // Index 0 is the youngest stage, DEPTH-1 drives the writeback outputs.
  stage_t [DEPTH-1:0] stage_q, stage_d;
  logic   [CNT_W-1:0] wb_cnt_q, wb_cnt_d;
  logic               rwe_out;

  assign rwe_out = stage_q[DEPTH-1].vld & stage_q[DEPTH-1].rwe;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    stage_d  = stage_q;
    wb_cnt_d = wb_cnt_q;

    if (flush) begin
      // Only the valid bits are killed; data fields keep their values.
      for (int k = 0; k < DEPTH; k++) begin
        stage_d[k].vld = 1'b0;
      end
    end else if (!stall) begin
      stage_d[0] = '{vld: bus.vld_i, rwe: bus.rwe_i,
                     res: bus.res_i, c_reg: bus.c_reg_i};
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end

    // A write held in the output stage by a stall is counted every cycle.
    if (rwe_out) begin
      wb_cnt_d = wb_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (rst) begin
      // NOTE: the whole stage array, data fields included, is cleared because
      // res_o, c_reg_o and the forwarding data must read 0 after reset.
      stage_q  <= '0;
      wb_cnt_q <= '0;
    end else begin
      stage_q  <= stage_d;
      wb_cnt_q <= wb_cnt_d;
    end
  end

  // Scan oldest to youngest so the last (youngest) match overrides older ones.
  function automatic fwd_t lookup(input stage_t [DEPTH-1:0] stages,
                                  input logic [REG_W-1:0]   reg_id);
    fwd_t r;
    r = '0;
    if (!(R0_ZERO != 0 && reg_id == '0)) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (stages[k].vld && stages[k].rwe && stages[k].c_reg == reg_id) begin
          r.hit  = 1'b1;
          r.data = stages[k].res;
        end
      end
    end
    return r;
  endfunction

  fwd_t fwd_a, fwd_b;

  assign fwd_a      = lookup(stage_q, fwd_reg_a);
  assign fwd_b      = lookup(stage_q, fwd_reg_b);
  assign fwd_hit_a  = fwd_a.hit;
  assign fwd_data_a = fwd_a.data;
  assign fwd_hit_b  = fwd_b.hit;
  assign fwd_data_b = fwd_b.data;

  assign bus.vld_o   = stage_q[DEPTH-1].vld;
  assign bus.rwe_o   = rwe_out;
  assign bus.res_o   = stage_q[DEPTH-1].res;
  assign bus.c_reg_o = stage_q[DEPTH-1].c_reg;
  assign wb_cnt      = wb_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: four configurations share one stimulus stream.
//   u_a: DEPTH=3, R0_ZERO=1     u_b: DEPTH=2
//   u_z: DEPTH=3, R0_ZERO=0     u_c: DEPTH=1, CNT_W=4
// Entries captured by the pipe are queued for u_a and u_b; monitors pop and
// compare whenever those pipes present a valid output entry.
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        vld, rwe;
  logic [15:0] res;
  logic [7:0]  c_reg;
  logic [7:0]  fwd_reg_a, fwd_reg_b;

  logic        hit_a [4];
  logic        hit_b [4];
  logic [15:0] dat_a [4];
  logic [15:0] dat_b [4];
  logic [15:0] cnt_a, cnt_b, cnt_z;
  logic [3:0]  cnt_c;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        rwe;
    logic [15:0] res;
    logic [7:0]  c_reg;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  mem_wb_if #(.DATA_W(16), .REG_W(8)) bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_drive
    assign bus[g].vld_i   = vld;
    assign bus[g].rwe_i   = rwe;
    assign bus[g].res_i   = res;
    assign bus[g].c_reg_i = c_reg;
  end

  mem_wb_pipe #(.DEPTH(3), .R0_ZERO(1)) u_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus[0]),
    .fwd_reg_a(fwd_reg_a), .fwd_hit_a(hit_a[0]), .fwd_data_a(dat_a[0]),
    .fwd_reg_b(fwd_reg_b), .fwd_hit_b(hit_b[0]), .fwd_data_b(dat_b[0]),
    .wb_cnt(cnt_a)
  );

  mem_wb_pipe #(.DEPTH(2)) u_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus[1]),
    .fwd_reg_a(fwd_reg_a), .fwd_hit_a(hit_a[1]), .fwd_data_a(dat_a[1]),
    .fwd_reg_b(fwd_reg_b), .fwd_hit_b(hit_b[1]), .fwd_data_b(dat_b[1]),
    .wb_cnt(cnt_b)
  );

  mem_wb_pipe #(.DEPTH(3), .R0_ZERO(0)) u_z (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus[2]),
    .fwd_reg_a(fwd_reg_a), .fwd_hit_a(hit_a[2]), .fwd_data_a(dat_a[2]),
    .fwd_reg_b(fwd_reg_b), .fwd_hit_b(hit_b[2]), .fwd_data_b(dat_b[2]),
    .wb_cnt(cnt_z)
  );

  mem_wb_pipe #(.DEPTH(1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus[3]),
    .fwd_reg_a(fwd_reg_a), .fwd_hit_a(hit_a[3]), .fwd_data_a(dat_a[3]),
    .fwd_reg_b(fwd_reg_b), .fwd_hit_b(hit_b[3]), .fwd_data_b(dat_b[3]),
    .wb_cnt(cnt_c)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of input; queue the entry if the pipe will capture it.
  task automatic drive(input logic v, input logic w, input logic [15:0] r,
                       input logic [7:0] c, input logic st, input logic fl);
    exp_t e;
    vld   = v;
    rwe   = w;
    res   = r;
    c_reg = c;
    stall = st;
    flush = fl;
    if (v && !st && !fl && !rst) begin
      e = '{rwe: w, res: r, c_reg: c};
      q_a.push_back(e);
      q_b.push_back(e);
    end
  endtask

  // Monitors: compare on the falling edge; a stalled output is compared every
  // cycle but popped only when it moves on. Flush/reset empty the queues.
  always @(negedge clk) begin
    if (bus[0].vld_o === 1'b1) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_a_unexpected: got res=%0h reg=%0h, expected no entry",
                 bus[0].res_o, bus[0].c_reg_o);
      end else begin
        check("sb_a_rwe", 32'(bus[0].rwe_o), 32'(q_a[0].rwe));
        check("sb_a_res", 32'(bus[0].res_o), 32'(q_a[0].res));
        check("sb_a_reg", 32'(bus[0].c_reg_o), 32'(q_a[0].c_reg));
        if (!stall) void'(q_a.pop_front());
      end
    end
    if (rst || flush) q_a.delete();
  end

  always @(negedge clk) begin
    if (bus[1].vld_o === 1'b1) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_b_unexpected: got res=%0h reg=%0h, expected no entry",
                 bus[1].res_o, bus[1].c_reg_o);
      end else begin
        check("sb_b_rwe", 32'(bus[1].rwe_o), 32'(q_b[0].rwe));
        check("sb_b_res", 32'(bus[1].res_o), 32'(q_b[0].res));
        check("sb_b_reg", 32'(bus[1].c_reg_o), 32'(q_b[0].c_reg));
        if (!stall) void'(q_b.pop_front());
      end
    end
    if (rst || flush) q_b.delete();
  end

  task automatic do_reset();
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    fwd_reg_a = 8'h05;
    fwd_reg_b = 8'h00;
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst_vld_o",  32'(bus[0].vld_o), 0);
    check("rst_rwe_o",  32'(bus[0].rwe_o), 0);
    check("rst_res_o",  32'(bus[0].res_o), 0);
    check("rst_c_reg",  32'(bus[0].c_reg_o), 0);
    check("rst_hit_a",  32'(hit_a[0]), 0);
    check("rst_data_a", 32'(dat_a[0]), 0);
    check("rst_cnt",    32'(cnt_a), 0);

    // Basic latency, DEPTH=3
    drive(1'b1, 1'b1, 16'h1234, 8'h05, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    check("lat_c1_rwe", 32'(bus[0].rwe_o), 0);
    check("lat_c1_vld", 32'(bus[0].vld_o), 0);
    tick();
    check("lat_c2_rwe", 32'(bus[0].rwe_o), 0);
    check("lat_c2_vld", 32'(bus[0].vld_o), 0);
    tick();
    check("lat_c3_rwe", 32'(bus[0].rwe_o), 1);
    check("lat_c3_res", 32'(bus[0].res_o), 'h1234);
    check("lat_c3_reg", 32'(bus[0].c_reg_o), 'h05);
    tick();
    check("lat_cnt", 32'(cnt_a), 1);

    // Stall, DEPTH=2: A and B in flight, C driven during stall
    do_reset();
    drive(1'b1, 1'b1, 16'h0011, 8'h01, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 16'h0022, 8'h02, 1'b0, 1'b0);
    tick();
    check("stl_pre_res", 32'(bus[1].res_o), 'h0011);
    check("stl_pre_cnt", 32'(cnt_b), 0);
    drive(1'b1, 1'b1, 16'h0033, 8'h03, 1'b1, 1'b0);
    repeat (3) tick();
    check("stl_hold_res", 32'(bus[1].res_o), 'h0011);
    check("stl_hold_rwe", 32'(bus[1].rwe_o), 1);
    check("stl_hold_cnt", 32'(cnt_b), 3);
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    tick();
    check("stl_rel_res", 32'(bus[1].res_o), 'h0022);
    check("stl_rel_cnt", 32'(cnt_b), 4);
    tick();
    check("stl_b_cnt", 32'(cnt_b), 5);
    check("stl_b_vld", 32'(bus[1].vld_o), 0);
    repeat (2) tick();

    // Flush together with stall, DEPTH=3
    do_reset();
    drive(1'b1, 1'b1, 16'h0101, 8'h04, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 16'h0202, 8'h05, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 16'h0303, 8'h06, 1'b0, 1'b0);
    tick();
    fwd_reg_a = 8'h05;
    fwd_reg_b = 8'h06;
    drive(1'b1, 1'b1, 16'h0404, 8'h08, 1'b1, 1'b1);
    #1;
    check("fl_pre_data_a", 32'(dat_a[0]), 'h0202);
    check("fl_pre_data_b", 32'(dat_b[0]), 'h0303);
    tick();
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    check("fl_vld_o",  32'(bus[0].vld_o), 0);
    check("fl_rwe_o",  32'(bus[0].rwe_o), 0);
    check("fl_hit_a",  32'(hit_a[0]), 0);
    check("fl_hit_b",  32'(hit_b[0]), 0);
    check("fl_data_a", 32'(dat_a[0]), 0);
    check("fl_res_o",  32'(bus[0].res_o), 'h0101);
    check("fl_cnt",    32'(cnt_a), 1);
    repeat (2) tick();
    check("fl_cnt_hold", 32'(cnt_a), 1);
    check("fl_vld_hold", 32'(bus[0].vld_o), 0);

    // Forwarding priority: stage 2 reg7=AAAA, stage 1 reg2, stage 0 reg7=BBBB
    do_reset();
    drive(1'b1, 1'b1, 16'hAAAA, 8'h07, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 16'h1111, 8'h02, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 16'hBBBB, 8'h07, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    fwd_reg_a = 8'h07;
    fwd_reg_b = 8'h09;
    #1;
    check("fp_hit_a",    32'(hit_a[0]), 1);
    check("fp_data_a",   32'(dat_a[0]), 'hBBBB);
    check("fp_hit_b",    32'(hit_b[0]), 0);
    check("fp_data_b",   32'(dat_b[0]), 0);
    check("fp_z_data_a", 32'(dat_a[2]), 'hBBBB);
    fwd_reg_b = 8'h02;
    #1;
    check("fp_mid_data_b", 32'(dat_b[0]), 'h1111);
    repeat (4) tick();

    // Zero register and rwe=0
    do_reset();
    drive(1'b1, 1'b1, 16'h00F0, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 16'h0330, 8'h03, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    fwd_reg_a = 8'h00;
    fwd_reg_b = 8'h03;
    #1;
    check("r0_hit_a",    32'(hit_a[0]), 0);
    check("r0_data_a",   32'(dat_a[0]), 0);
    check("r0_hit_b",    32'(hit_b[0]), 0);
    check("r0z_hit_a",   32'(hit_a[2]), 1);
    check("r0z_data_a",  32'(dat_a[2]), 'h00F0);
    check("r0z_hit_b",   32'(hit_b[2]), 0);
    repeat (3) tick();

    // Counter wrap with CNT_W=4, then reset with entries in flight
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 16'(i + 'h100), 8'(i + 1), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    tick();
    check("wrap_cnt", 32'(cnt_c), 1);
    drive(1'b1, 1'b1, 16'h5555, 8'h0A, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 16'h6666, 8'h0B, 1'b0, 1'b0);
    tick();
    fwd_reg_a = 8'h0A;
    do_reset();
    check("mr_vld_o",  32'(bus[0].vld_o), 0);
    check("mr_rwe_o",  32'(bus[0].rwe_o), 0);
    check("mr_res_o",  32'(bus[0].res_o), 0);
    check("mr_c_reg",  32'(bus[0].c_reg_o), 0);
    check("mr_hit_a",  32'(hit_a[0]), 0);
    check("mr_data_a", 32'(dat_a[0]), 0);
    check("mr_cnt_a",  32'(cnt_a), 0);
    check("mr_c_vld",  32'(bus[3].vld_o), 0);
    check("mr_c_res",  32'(bus[3].res_o), 0);
    check("mr_cnt_c",  32'(cnt_c), 0);

    repeat (4) tick();
    check("sb_a_drained", 32'(q_a.size()), 0);
    check("sb_b_drained", 32'(q_b.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
